// File: rtl/rs_syndrome_par.sv
// Parallel RS(544,522) syndrome calculator over GF(2^10): folds P symbols per beat into
// S1..S2T and holds the result in a single-entry buffer that feeds the key-equation solver.
module rs_syndrome_par #(
    parameter int T = 11,
    parameter int W = 10,
    parameter int N = 544,
    parameter int P = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [P-1:0][W-1:0]  in_sym_i,
    input  logic                 in_sop_i,
    input  logic                 in_eop_i,
    output logic [2*T:0][W-1:0]  syn_o,
    output logic                 syn_valid_o,
    input  logic                 syn_ready_i,
    output logic                 syn_zero_o,
    output logic                 frame_err_o
);

    localparam int NB    = N / P;
    localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int ORDER = (1 << W) - 1;
    localparam logic [W-1:0] POLY_LOW = W'(10'h009);  // x^3 + 1 from p(x)=x^10+x^3+1

    if (N % P != 0) begin : g_bad_beat
        $fatal(1, "rs_syndrome_par: N must be a multiple of P");
    end

    typedef enum logic {IDLE, ACC} state_t;

    // Multiply by alpha^e; e is always an elaboration constant, so this folds to an XOR network.
    function automatic logic [W-1:0] mul_alpha_pow(input logic [W-1:0] x, input int e);
        logic [W-1:0] y;
        y = x;
        for (int n = 0; n < e % ORDER; n++) begin
            y = {y[W-2:0], 1'b0} ^ (y[W-1] ? POLY_LOW : '0);
        end
        return y;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, pos;
    logic [W-1:0]   acc_q [1:2*T];
    logic [W-1:0]   acc_d [1:2*T];
    logic           acc_we, complete, err_d, acc_all_zero, last_pending;

    for (genvar j = 1; j <= 2*T; j++) begin : g_syn
        logic [W-1:0] beat_sum;
        logic [W-1:0] acc_shift;

        always_comb begin
            beat_sum = '0;
            for (int k = 0; k < P; k++) begin
                beat_sum ^= mul_alpha_pow(in_sym_i[k], j * (P - 1 - k));
            end
        end

        assign acc_shift = mul_alpha_pow(acc_q[j], j * P);
        assign acc_d[j]  = (in_sop_i ? '0 : acc_shift) ^ beat_sum;
    end

    always_comb begin
        acc_all_zero = 1'b1;
        for (int j = 1; j <= 2*T; j++) begin
            if (acc_d[j] != '0) acc_all_zero = 1'b0;
        end
    end

    // Stall only the beat that could complete a frame while the buffer is still occupied.
    assign last_pending = (NB == 1) || (state_q == ACC && cnt_q == CW'(NB - 1));
    assign in_ready_o   = !(syn_valid_o && !syn_ready_i && last_pending);
    assign pos          = in_sop_i ? '0 : cnt_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        acc_we   = 1'b0;
        complete = 1'b0;
        if (in_valid_i && in_ready_o) begin
            if (state_q == IDLE && !in_sop_i) begin
                err_d = 1'b1;
            end else begin
                acc_we = 1'b1;
                if (state_q == ACC && in_sop_i) err_d = 1'b1;
                if (pos == CW'(NB - 1) || in_eop_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (pos == CW'(NB - 1) && in_eop_i) complete = 1'b1;
                    else                                err_d    = 1'b1;
                end else begin
                    state_d = ACC;
                    cnt_d   = pos + CW'(1);
                end
            end
        end
    end

    // NOTE: the accumulators and the output buffer are ordinary flops, so reset clears them too.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_err_o <= 1'b0;
            syn_valid_o <= 1'b0;
            syn_zero_o  <= 1'b0;
            syn_o       <= '0;
            for (int j = 1; j <= 2*T; j++) acc_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_err_o <= err_d;
            if (acc_we) begin
                for (int j = 1; j <= 2*T; j++) acc_q[j] <= acc_d[j];
            end
            if (complete) begin
                syn_valid_o <= 1'b1;
                syn_zero_o  <= acc_all_zero;
                for (int j = 1; j <= 2*T; j++) syn_o[j] <= acc_d[j];
            end else if (syn_ready_i) begin
                syn_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_syndrome_par.sv
// Self-checking bench for rs_syndrome_par: random and directed codewords compared against
// syndromes evaluated straight from S_j = sum r_i * alpha^(i*j), plus framing/backpressure/reset.
module tb_rs_syndrome_par;

    localparam int T  = 11;
    localparam int W  = 10;
    localparam int N  = 544;
    localparam int P  = 16;
    localparam int NB = N / P;
    localparam int BUDGET = 1000;

    typedef logic [2*T:0][W-1:0] syn_t;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [P-1:0][W-1:0] in_sym_i;
    logic                in_sop_i;
    logic                in_eop_i;
    syn_t                syn_o;
    logic                syn_valid_o;
    logic                syn_ready_i;
    logic                syn_zero_o;
    logic                frame_err_o;

    rs_syndrome_par #(.T(T), .W(W), .N(N), .P(P)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_sym_i    (in_sym_i),
        .in_sop_i    (in_sop_i),
        .in_eop_i    (in_eop_i),
        .syn_o       (syn_o),
        .syn_valid_o (syn_valid_o),
        .syn_ready_i (syn_ready_i),
        .syn_zero_o  (syn_zero_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int           checks = 0;
    int           failures = 0;
    int           err_cnt = 0;
    logic [W-1:0] cw [0:N-1];
    logic [W-1:0] apow [0:1022];
    syn_t         exp_q [$];
    syn_t         exp_s;
    syn_t         hold_syn;
    logic         hold_prev = 1'b0;
    bit           done;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] p;
        logic [W-1:0] aa;
        p  = '0;
        aa = a;
        for (int n = 0; n < W; n++) begin
            if (b[n]) p ^= aa;
            aa = {aa[W-2:0], 1'b0} ^ (aa[W-1] ? 10'h009 : 10'h000);
        end
        return p;
    endfunction

    function automatic syn_t model_syn();
        syn_t s;
        s = '0;
        for (int j = 1; j <= 2*T; j++) begin
            for (int i = 0; i < N; i++) begin
                if (cw[i] != '0) s[j] ^= gf_mul(cw[i], apow[(i * j) % 1023]);
            end
        end
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) cw[i] = W'($urandom_range(0, 1023));
    endtask

    task automatic fill_zero();
        for (int i = 0; i < N; i++) cw[i] = '0;
    endtask

    task automatic idle_inputs();
        in_valid_i = 1'b0;
        in_sop_i   = 1'($urandom_range(0, 1));
        in_eop_i   = 1'($urandom_range(0, 1));
        for (int k = 0; k < P; k++) in_sym_i[k] = W'($urandom_range(0, 1023));
    endtask

    task automatic set_beat(input int b, input logic sop, input logic eop);
        in_valid_i = 1'b1;
        in_sop_i   = sop;
        in_eop_i   = eop;
        for (int k = 0; k < P; k++) in_sym_i[k] = cw[N - 1 - (b * P + k)];
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic put_beat(input int b, input logic sop, input logic eop);
        int waited;
        set_beat(b, sop, eop);
        waited = 0;
        forever begin
            #1;
            if (in_ready_o || waited >= BUDGET) break;
            @(negedge clk_i);
            waited++;
        end
        if (!in_ready_o) check("ready_timeout", 256'(in_ready_o), 256'(1));
        @(posedge clk_i);
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic send_frame(input bit gaps, input bit lat);
        exp_q.push_back(model_syn());
        for (int b = 0; b < NB; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
            if (lat && b == NB - 1) check("pre_valid", 256'(syn_valid_o), 256'(0));
            put_beat(b, b == 0, b == NB - 1);
        end
        if (lat) check("latency_valid", 256'(syn_valid_o), 256'(1));
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk_i);
        check("drain", 256'(exp_q.size()), 256'(0));
    endtask

    // Scoreboard: every transfer must match the oldest expected frame, and held data must not move.
    always begin
        @(negedge clk_i);
        #2;
        if (frame_err_o) err_cnt++;
        if (hold_prev) begin
            check("hold_valid", 256'(syn_valid_o), 256'(1));
            check("hold_data", 256'(syn_o), 256'(hold_syn));
        end
        if (syn_valid_o && syn_ready_i) begin
            check("frame_expected", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                exp_s = exp_q.pop_front();
                check("syn", 256'(syn_o), 256'(exp_s));
                check("syn_zero", 256'(syn_zero_o), 256'(exp_s == '0));
            end
        end
        hold_prev = syn_valid_o && !syn_ready_i;
        hold_syn  = syn_o;
    end

    initial begin
        int err0;
        apow[0] = 10'h001;
        for (int e = 1; e < 1023; e++) apow[e] = gf_mul(apow[e-1], 10'h002);

        rst_ni      = 1'b0;
        syn_ready_i = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_valid", 256'(syn_valid_o), 256'(0));
        check("rst_zero", 256'(syn_zero_o), 256'(0));
        check("rst_err", 256'(frame_err_o), 256'(0));
        check("rst_syn", 256'(syn_o), 256'(0));
        check("rst_ready", 256'(in_ready_o), 256'(1));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // All-zero codeword
        fill_zero();
        send_frame(1'b0, 1'b1);
        check("zero_flag", 256'(syn_zero_o), 256'(1));

        // Single error r0 = 1: every syndrome is 1
        fill_zero();
        cw[0] = 10'h001;
        send_frame(1'b0, 1'b1);
        check("r0_zero_flag", 256'(syn_zero_o), 256'(0));
        check("r0_s22", 256'(syn_o[22]), 256'(10'h001));

        // Single error r1 = 0x155
        fill_zero();
        cw[1] = 10'h155;
        send_frame(1'b0, 1'b1);
        check("r1_s1", 256'(syn_o[1]), 256'(10'h2AA));
        check("r1_s0", 256'(syn_o[0]), 256'(0));

        // Random frames, random input gaps and random solver backpressure
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    fill_random();
                    send_frame(1'b1, 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk_i);
                    syn_ready_i = ($urandom_range(0, 3) != 0);
                end
                syn_ready_i = 1'b1;
            end
        join
        wait_drain();

        // Back-to-back frames with the solver stalled for 50 cycles
        @(negedge clk_i);
        syn_ready_i = 1'b0;
        fill_random();
        send_frame(1'b0, 1'b0);
        fill_random();
        exp_q.push_back(model_syn());
        for (int b = 0; b < NB - 1; b++) put_beat(b, b == 0, 1'b0);
        set_beat(NB - 1, 1'b0, 1'b1);
        #1;
        check("stall_ready", 256'(in_ready_o), 256'(0));
        repeat (50) @(negedge clk_i);
        #1;
        check("stall_ready_late", 256'(in_ready_o), 256'(0));
        check("stall_valid", 256'(syn_valid_o), 256'(1));
        syn_ready_i = 1'b1;
        #1;
        check("release_ready", 256'(in_ready_o), 256'(1));
        @(posedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        check("reload_valid", 256'(syn_valid_o), 256'(1));
        wait_drain();

        // Beat without sop while idle is dropped with an error pulse
        err0 = err_cnt;
        fill_random();
        put_beat(0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        #3;
        check("nosop_err", 256'(err_cnt - err0), 256'(1));
        check("nosop_valid", 256'(syn_valid_o), 256'(0));

        // eop on the 10th beat: one pulse, no result
        err0 = err_cnt;
        put_beat(0, 1'b1, 1'b0);
        for (int b = 1; b < 9; b++) put_beat(b, 1'b0, 1'b0);
        put_beat(9, 1'b0, 1'b1);
        repeat (3) @(negedge clk_i);
        #3;
        check("eop_early_err", 256'(err_cnt - err0), 256'(1));
        check("eop_early_valid", 256'(syn_valid_o), 256'(0));

        // sop after 20 beats aborts the partial frame; the new frame is clean
        err0 = err_cnt;
        put_beat(0, 1'b1, 1'b0);
        for (int b = 1; b < 20; b++) put_beat(b, 1'b0, 1'b0);
        fill_random();
        send_frame(1'b0, 1'b1);
        wait_drain();
        check("sop_abort_err", 256'(err_cnt - err0), 256'(1));

        // Reset in the middle of a frame: quiet, then a correct full frame
        err0 = err_cnt;
        fill_random();
        for (int b = 0; b < 17; b++) put_beat(b, b == 0, 1'b0);
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("mid_rst_valid", 256'(syn_valid_o), 256'(0));
        check("mid_rst_zero", 256'(syn_zero_o), 256'(0));
        check("mid_rst_syn", 256'(syn_o), 256'(0));
        check("mid_rst_ready", 256'(in_ready_o), 256'(1));
        rst_ni = 1'b1;
        @(negedge clk_i);
        fill_random();
        send_frame(1'b1, 1'b1);
        wait_drain();
        check("mid_rst_err", 256'(err_cnt - err0), 256'(0));

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
